// File: rtl/mdu_pkg.sv
// Shared definitions for the multicycle multiply/divide unit:
// operation encodings and the controller state type.
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Radix-2 iterative multiply/divide unit owning the HI/LO register pair.
// Works on operand magnitudes and applies sign correction in a final FIX cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mdu_pkg::*;

    localparam int CW = $clog2(WIDTH);

    mdu_state_t         state;
    mdu_state_t         next_state;
    logic [CW-1:0]      cnt;
    logic               div_q;
    logic               neg_ab;
    logic               neg_a;
    logic               dz_flag;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               is_div;
    logic               is_signed;
    logic               b_zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v);
        return {WIDTH{1'b0}} - v;
    endfunction

    // The most negative value maps to 2^(WIDTH-1), which is still exact as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? negate_w(v) : v;
    endfunction

    always_comb begin
        is_div    = op[1];
        is_signed = ~op[0];
        b_zero    = (b == {WIDTH{1'b0}});
        a_mag     = magnitude(a, is_signed);
        b_mag     = magnitude(b, is_signed);
    end

    // Multiply keeps the multiplier in the low half; divide keeps {rem, quot}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        diff      = rem_shift - {1'b0, operand};
        acc_next  = {mul_sum, acc[WIDTH-1:1]};
        if (div_q) begin
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod_fix = neg_ab ? ({(2*WIDTH){1'b0}} - acc) : acc;
        quot_fix = neg_ab ? negate_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fix  = neg_a  ? negate_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        hi_fix   = div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
        lo_fix   = div_q ? quot_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (is_div && b_zero) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH-1)) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        div_zero = (state == DONE) && dz_flag;
        hi       = hi_q;
        lo       = lo_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            div_q   <= 1'b0;
            neg_ab  <= 1'b0;
            neg_a   <= 1'b0;
            dz_flag <= 1'b0;
            operand <= '0;
            acc     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        div_q   <= is_div;
                        neg_ab  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_a   <= is_signed && a[WIDTH-1];
                        dz_flag <= is_div && b_zero;
                        if (is_div) begin
                            acc     <= {{WIDTH{1'b0}}, a_mag};
                            operand <= b_mag;
                        end else begin
                            acc     <= {{WIDTH{1'b0}}, b_mag};
                            operand <= a_mag;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi_q <= hi_fix;
                    lo_q <= lo_fix;
                end
                DONE: begin
                    dz_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a behavioural model queues expected HI/LO,
// latency and divide-by-zero status, which are compared when done pulses.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;
    localparam int MAX_WAIT = 100;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Independent model built on 64-bit native arithmetic.
    task automatic model_op(input logic [1:0] m_op, input logic [W-1:0] m_a,
                            input logic [W-1:0] m_b, output exp_t e);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        e.dz  = 1'b0;
        e.lat = W + 1;
        case (m_op)
            MDU_MULT: begin
                sa = longint'($signed(m_a));
                sb = longint'($signed(m_b));
                p  = 64'(sa * sb);
                model_hi = p[63:32];
                model_lo = p[31:0];
            end
            MDU_MULTU: begin
                p = {32'b0, m_a} * {32'b0, m_b};
                model_hi = p[63:32];
                model_lo = p[31:0];
            end
            default: begin
                if (m_b == '0) begin
                    e.dz  = 1'b1;
                    e.lat = 0;
                end else if (m_op == MDU_DIV) begin
                    sa = longint'($signed(m_a));
                    sb = longint'($signed(m_b));
                    q  = sa / sb;
                    r  = sa % sb;
                    p  = 64'(q);
                    model_lo = p[31:0];
                    p  = 64'(r);
                    model_hi = p[31:0];
                end else begin
                    model_lo = m_a / m_b;
                    model_hi = m_a % m_b;
                end
            end
        endcase
        e.hi = model_hi;
        e.lo = model_lo;
    endtask

    task automatic apply_stimulus(input logic [1:0] s_op, input logic [W-1:0] s_a,
                                  input logic [W-1:0] s_b);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = s_op;
        a     = s_a;
        b     = s_b;
        model_op(s_op, s_a, s_b, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = '1;
        b     = '1;
    endtask

    task automatic collect_result(input string tag, input bit poke);
        int   edges;
        exp_t e;
        edges = 0;
        check_output({tag, "_busy"}, 64'(busy), 64'd1);
        while (!done && edges < MAX_WAIT) begin
            if (poke && edges == 5) begin
                start = 1'b1;
                op    = MDU_MULTU;
                a     = 32'd1234;
                b     = 32'd5678;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
        end
        if (!done) begin
            check_output({tag, "_timeout_done"}, 64'(done), 64'd1);
        end else if (sb_q.size() == 0) begin
            check_output({tag, "_unexpected_done"}, 64'(done), 64'd0);
        end else begin
            e = sb_q.pop_front();
            check_output({tag, "_latency"}, 64'(edges), 64'(e.lat));
            check_output({tag, "_hi"}, 64'(hi), 64'(e.hi));
            check_output({tag, "_lo"}, 64'(lo), 64'(e.lo));
            check_output({tag, "_div_zero"}, 64'(div_zero), 64'(e.dz));
            @(posedge clk);
            #1;
            check_output({tag, "_done_pulse"}, 64'(done), 64'd0);
            check_output({tag, "_idle_busy"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = MDU_MULT;
        a     = '0;
        b     = '0;
        #12;
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_done", 64'(done), 64'd0);
        check_output("reset_div_zero", 64'(div_zero), 64'd0);
        check_output("reset_hi", 64'(hi), 64'd0);
        check_output("reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        apply_stimulus(MDU_MULT, 32'd7, 32'hFFFFFFFD);
        collect_result("mult_neg", 1'b0);
        apply_stimulus(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        collect_result("multu_max", 1'b0);
        apply_stimulus(MDU_DIV, 32'hFFFFFFF9, 32'd2);
        collect_result("div_neg", 1'b0);
        apply_stimulus(MDU_DIVU, 32'd100, 32'd7);
        collect_result("divu", 1'b0);
        apply_stimulus(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
        collect_result("div_ovf", 1'b0);
        apply_stimulus(MDU_DIVU, 32'd55, 32'd0);
        collect_result("divu_zero", 1'b0);
        apply_stimulus(MDU_DIV, 32'h80000000, 32'd0);
        collect_result("div_zero", 1'b0);
        apply_stimulus(MDU_MULT, 32'h80000000, 32'h80000000);
        collect_result("mult_minmin", 1'b0);
        apply_stimulus(MDU_DIV, 32'd9, 32'hFFFFFFFC);
        collect_result("div_pos_neg", 1'b0);
        apply_stimulus(MDU_DIV, 32'h12345678, 32'h00ABCDEF);
        collect_result("start_ignored", 1'b1);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]   r_op;
            logic [W-1:0] r_a;
            logic [W-1:0] r_b;
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = (i == 5) ? '0 : $urandom;
            if (i[0]) r_b = r_b >> $urandom_range(0, 28);
            apply_stimulus(r_op, r_a, r_b);
            collect_result($sformatf("rand%0d", i), 1'b0);
        end

        apply_stimulus(MDU_MULT, 32'h12345678, 32'h9ABCDEF0);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("abort_busy", 64'(busy), 64'd0);
        check_output("abort_done", 64'(done), 64'd0);
        check_output("abort_div_zero", 64'(div_zero), 64'd0);
        check_output("abort_hi", 64'(hi), 64'd0);
        check_output("abort_lo", 64'(lo), 64'd0);
        sb_q.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(MDU_MULT, 32'd3, 32'd5);
        collect_result("mult_after_reset", 1'b0);

        check_output("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multicycle multiply/divide unit for the multicycle MIPS datapath, owning the HI/LO register pair used by MULT, MULTU, DIV, DIVU, MFHI and MFLO. The control unit launches an operation with a one-cycle `start` pulse and waits on `busy` and `done`. The unit produces a full 2×WIDTH product, or a quotient and remainder, using a radix-2 iterative algorithm. It adds width generality, unsigned modes and divide-by-zero reporting.

## Interface
- `WIDTH`, default 32: operand width and the width of each of HI and LO; must be ≥ 4.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: launch request; sampled only in IDLE.
- `op` in 2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with `start`.
- `a` in WIDTH: multiplicand or dividend (from REG_A); sampled with `start`.
- `b` in WIDTH: multiplier or divisor (from REG_B); sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done` out 1: one-cycle pulse; HI/LO hold the new result in the same cycle.
- `div_zero` out 1: one-cycle pulse, coincident with `done`, on DIV/DIVU with `b`=0.
- `hi` out WIDTH: HI register (upper product half, or remainder).
- `lo` out WIDTH: LO register (lower product half, or quotient).

## Operation
- States:
  - IDLE
  - RUN: iteration counter `cnt` counts 0..WIDTH-1.
  - FIX: sign correction and HI/LO write.
  - DONE
- IDLE with `start`=1:
  - Latch `op`.
  - Latch |a| and |b| for signed ops; raw values for unsigned ops.
  - Record the result-sign flags: product sign a^b; quotient sign a^b; remainder sign a.
  - Go to RUN, with one exception: DIV/DIVU with `b`=0 goes directly to DONE, sets `div_zero`, and leaves HI/LO unchanged.
- RUN, multiply: shift-add on magnitudes into a 2×WIDTH accumulator. Each step conditionally adds the multiplicand shifted into the upper half, then shifts right 1.
- RUN, divide: restoring division. Each step shifts the {rem, quot} register left 1, trial-subtracts the divisor (WIDTH+1-bit subtraction), and keeps the result if it is non-negative, setting the quotient bit.
- After `cnt`=WIDTH-1, go to FIX.
- FIX:
  - Negate the product, quotient and/or remainder (two's complement, modulo width) per the sign flags.
  - Write HI/LO.
  - Go to DONE.
- DONE: assert `done` (and `div_zero` if set), then go to IDLE.
- Arithmetic rules:
  - Signed division truncates toward zero.
  - The remainder takes the sign of the dividend.
  - −2^(WIDTH−1) / −1 gives LO = 0x80…0 and HI = 0; no trap.
  - The magnitude of −2^(WIDTH−1) is handled as an unsigned value of 2^(WIDTH−1).
- `start` outside IDLE is ignored; no queueing.
- HI/LO change only in FIX. They hold their values otherwise, including across a divide-by-zero.

## Timing
- Reset (asynchronous, `reset`=0): state IDLE; `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, `cnt`=0.
- Reset mid-operation: the operation is aborted immediately and the result is lost.
- Accepted `start` at edge T:
  - RUN covers edges T+1 .. T+WIDTH.
  - FIX is at edge T+WIDTH+1.
  - `done` is high during cycle T+WIDTH+2; latency is WIDTH+2 cycles (34 for WIDTH=32).
- Divide-by-zero: `done` and `div_zero` are high during cycle T+1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `start` in the same cycle as `done` is ignored, because the state is still DONE.

## Structure
- Shared package `mdu_pkg`:
  - op encoding constants MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
  - state enum (IDLE, RUN, FIX, DONE).
- Single module. Magnitude and negate logic is local functions; no sub-module is warranted.
- Counter width is $clog2(WIDTH).

## Test plan
- MULT, a=7, b=0xFFFFFFFD (−3) -> `done` at start+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV, a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU, a=100, b=7 -> lo=14, hi=2.
- DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then DIVU with b=0 -> `done` and `div_zero` at start+1; hi/lo unchanged.
- `start` pulsed while `busy` with different operands -> ignored; the first result is delivered unchanged at start+34.
- `reset` pulled low at RUN cycle 10 -> all outputs 0 asynchronously. After release, a new MULT 3×5 -> lo=15, hi=0.
